// File: rtl/ghost_dist_calc.sv
// Ghost chase helper: computes squared distances from each neighbour tile of the
// ghost to its target, with tunnel wrap, wall/reverse masking, over a 7-state FSM.
module ghost_dist_calc #(
    parameter int COORD_W = 6,
    parameter int GRID_W  = 28,
    parameter int GRID_H  = 31
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic [COORD_W-1:0] ghost_x,
    input  logic [COORD_W-1:0] ghost_y,
    input  logic [COORD_W-1:0] target_x,
    input  logic [COORD_W-1:0] target_y,
    input  logic [3:0]         wall_mask,
    input  logic [1:0]         dir_cur,
    output logic               busy,
    output logic               done,
    output logic               dead_end,
    output logic [31:0]        dist_up,
    output logic [31:0]        dist_left,
    output logic [31:0]        dist_down,
    output logic [31:0]        dist_right,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CALC0 = 3'd2,
        S_CALC1 = 3'd3,
        S_CALC2 = 3'd4,
        S_CALC3 = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam int SQ_W = 2 * COORD_W + 2;
    localparam logic [COORD_W-1:0] X_MAX  = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W:0]   Y_TOP  = (COORD_W + 1)'(GRID_H);
    localparam logic [COORD_W:0]   Y_LAST = (COORD_W + 1)'(GRID_H - 1);

    state_t state_q, state_d;
    logic   ready_q;

    logic [COORD_W-1:0] gx_q, gy_q, tx_q, ty_q;
    logic [3:0]         wall_q;
    logic [1:0]         dir_q;

    logic [COORD_W-1:0] nx_q [4];
    logic [COORD_W-1:0] ny_q [4];
    logic [3:0]         forb_q;
    logic               dead_pend_q;
    logic [31:0]        part_q [3];
    logic [31:0]        dist_q [4];
    logic               dead_q;

    logic               accept;
    logic [COORD_W-1:0] nx_d [4];
    logic [COORD_W-1:0] ny_d [4];
    logic [COORD_W:0]   gy_ext;
    logic               vblk_up, vblk_dn;
    logic [3:0]         rev_mask, blocked, forb_raw, forb_d;
    logic               dead_d;

    logic [1:0]         sel;
    logic [COORD_W:0]   dx, dy;
    logic [SQ_W-1:0]    dx_ext, dy_ext, sq_sum;
    logic [31:0]        dist_k;

    // ready_q blocks acceptance in the first cycle after reset release
    assign accept = (state_q == S_IDLE) && start && ready_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_LOAD;
            S_LOAD:  state_d = S_CALC0;
            S_CALC0: state_d = S_CALC1;
            S_CALC1: state_d = S_CALC2;
            S_CALC2: state_d = S_CALC3;
            S_CALC3: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Neighbour tiles and forbidden set, evaluated from the latched request
    always_comb begin
        gy_ext  = {1'b0, gy_q};
        vblk_up = (gy_q == '0) || (gy_ext > Y_TOP);
        vblk_dn = (gy_ext >= Y_LAST);

        nx_d[0] = gx_q;
        ny_d[0] = gy_q - COORD_W'(1);
        nx_d[1] = (gx_q == '0) ? X_MAX : gx_q - COORD_W'(1);
        ny_d[1] = gy_q;
        nx_d[2] = gx_q;
        ny_d[2] = gy_q + COORD_W'(1);
        nx_d[3] = (gx_q == X_MAX) ? '0 : gx_q + COORD_W'(1);
        ny_d[3] = gy_q;

        rev_mask = 4'b0001 << (dir_q ^ 2'd2);
        blocked  = wall_q | {1'b0, vblk_dn, 1'b0, vblk_up};
        forb_raw = blocked | rev_mask;
        // Reversing is allowed only as the last resort, and only if not walled
        if ((&forb_raw) && ((blocked & rev_mask) == 4'b0000)) begin
            forb_d = forb_raw & ~rev_mask;
        end else begin
            forb_d = forb_raw;
        end
        dead_d = &forb_d;
    end

    // Single shared squarer pair, time-multiplexed over CALC0..CALC3
    always_comb begin
        sel = 2'd0;
        unique case (state_q)
            S_CALC1: sel = 2'd1;
            S_CALC2: sel = 2'd2;
            S_CALC3: sel = 2'd3;
            default: sel = 2'd0;
        endcase
        dx     = {1'b0, nx_q[sel]} - {1'b0, tx_q};
        dy     = {1'b0, ny_q[sel]} - {1'b0, ty_q};
        dx_ext = {{(COORD_W + 1){dx[COORD_W]}}, dx};
        dy_ext = {{(COORD_W + 1){dy[COORD_W]}}, dy};
        sq_sum = dx_ext * dx_ext + dy_ext * dy_ext;
        dist_k = forb_q[sel] ? 32'hFFFF_FFFF : {{(32 - SQ_W){1'b0}}, sq_sum};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            tx_q        <= '0;
            ty_q        <= '0;
            wall_q      <= '0;
            dir_q       <= '0;
            forb_q      <= '0;
            dead_pend_q <= 1'b0;
            dead_q      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                nx_q[i]   <= '0;
                ny_q[i]   <= '0;
                dist_q[i] <= 32'hFFFF_FFFF;
            end
            for (int i = 0; i < 3; i++) begin
                part_q[i] <= 32'hFFFF_FFFF;
            end
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            if (accept) begin
                gx_q   <= ghost_x;
                gy_q   <= ghost_y;
                tx_q   <= target_x;
                ty_q   <= target_y;
                wall_q <= wall_mask;
                dir_q  <= dir_cur;
            end
            if (state_q == S_LOAD) begin
                for (int i = 0; i < 4; i++) begin
                    nx_q[i] <= nx_d[i];
                    ny_q[i] <= ny_d[i];
                end
                forb_q      <= forb_d;
                dead_pend_q <= dead_d;
            end
            if ((state_q == S_CALC0) || (state_q == S_CALC1) || (state_q == S_CALC2)) begin
                part_q[sel] <= dist_k;
            end
            // All four results land together so DONE presents a complete set
            if (state_q == S_CALC3) begin
                dist_q[0] <= part_q[0];
                dist_q[1] <= part_q[1];
                dist_q[2] <= part_q[2];
                dist_q[3] <= dist_k;
                dead_q    <= dead_pend_q;
            end
        end
    end

    assign busy       = (state_q == S_LOAD) || (state_q == S_CALC0) || (state_q == S_CALC1) ||
                        (state_q == S_CALC2) || (state_q == S_CALC3);
    assign done       = (state_q == S_DONE);
    assign dead_end   = dead_q;
    assign dist_up    = dist_q[0];
    assign dist_left  = dist_q[1];
    assign dist_down  = dist_q[2];
    assign dist_right = dist_q[3];
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ghost_dist_calc.sv
// Directed bench for ghost_dist_calc: table of hand-computed vectors plus
// back-to-back, ignored-start and mid-operation reset sequences.
module tb_ghost_dist_calc;

  localparam logic [31:0] NF = 32'hFFFF_FFFF;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  ghost_x = '0, ghost_y = '0, target_x = '0, target_y = '0;
  logic [3:0]  wall_mask = '0;
  logic [1:0]  dir_cur = '0;
  logic        busy, done, dead_end;
  logic [31:0] dist_up, dist_left, dist_down, dist_right;
  logic [2:0]  dbg_state;

  ghost_dist_calc dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .ghost_x(ghost_x), .ghost_y(ghost_y), .target_x(target_x), .target_y(target_y),
    .wall_mask(wall_mask), .dir_cur(dir_cur),
    .busy(busy), .done(done), .dead_end(dead_end),
    .dist_up(dist_up), .dist_left(dist_left), .dist_down(dist_down), .dist_right(dist_right),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  typedef struct {
    logic [5:0]  gx, gy, tx, ty;
    logic [3:0]  wall;
    logic [1:0]  dir;
    logic [31:0] eu, el, ed, er;
    logic        edead;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] prev [4];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    ghost_x = v.gx; ghost_y = v.gy; target_x = v.tx; target_y = v.ty;
    wall_mask = v.wall; dir_cur = v.dir;
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_hold_up"}, dist_up, prev[0]);
    chk({tag, "_hold_left"}, dist_left, prev[1]);
    chk({tag, "_hold_down"}, dist_down, prev[2]);
    chk({tag, "_hold_right"}, dist_right, prev[3]);
  endtask

  // scoreboard: pops the four expected distances in up/left/down/right order
  task automatic chk_result(input string tag, input logic edead);
    logic [31:0] e;
    e = exp_q.pop_front(); chk({tag, "_up"}, dist_up, e); prev[0] = e;
    e = exp_q.pop_front(); chk({tag, "_left"}, dist_left, e); prev[1] = e;
    e = exp_q.pop_front(); chk({tag, "_down"}, dist_down, e); prev[2] = e;
    e = exp_q.pop_front(); chk({tag, "_right"}, dist_right, e); prev[3] = e;
    chk({tag, "_dead"}, dead_end, edead);
  endtask

  task automatic push_exp(input vec_t v);
    exp_q.push_back(v.eu); exp_q.push_back(v.el);
    exp_q.push_back(v.ed); exp_q.push_back(v.er);
  endtask

  // one full operation; inputs are scrambled after acceptance and a stray
  // start pulse is placed in CALC1
  task automatic run_op(input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge Clk);
    drive(vecs[idx]);
    push_exp(vecs[idx]);
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    ghost_x = 6'($urandom_range(0, 63)); ghost_y = 6'($urandom_range(0, 63));
    target_x = 6'($urandom_range(0, 63)); target_y = 6'($urandom_range(0, 63));
    wall_mask = 4'($urandom_range(0, 15)); dir_cur = 2'($urandom_range(0, 3));
    for (int c = 1; c <= 5; c++) begin
      @(negedge Clk);
      chk($sformatf("%s_busy_c%0d", tag, c), busy, 1'b1);
      chk($sformatf("%s_nodone_c%0d", tag, c), done, 1'b0);
      chk_hold($sformatf("%s_c%0d", tag, c));
      if (c == 3) start = 1'b1;
      if (c == 4) start = 1'b0;
    end
    @(negedge Clk);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    chk_result(tag, vecs[idx].edead);
    @(negedge Clk);
    chk({tag, "_done_once"}, done, 1'b0);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_state"}, dbg_state, 3'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_dead"}, dead_end, 1'b0);
    chk({tag, "_state"}, dbg_state, 3'd0);
    chk({tag, "_up"}, dist_up, NF);
    chk({tag, "_left"}, dist_left, NF);
    chk({tag, "_down"}, dist_down, NF);
    chk({tag, "_right"}, dist_right, NF);
  endtask

  initial begin
    int done_cnt, first, last;

    vecs[0] = '{6'd10, 6'd10, 6'd13, 6'd6, 4'b0000, 2'd3, 32'd18, NF, 32'd34, 32'd20, 1'b0};
    vecs[1] = '{6'd0, 6'd14, 6'd27, 6'd14, 4'b0101, 2'd1, NF, 32'd0, NF, NF, 1'b0};
    vecs[2] = '{6'd5, 6'd5, 6'd5, 6'd1, 4'b1011, 2'd0, NF, NF, 32'd25, NF, 1'b0};
    vecs[3] = '{6'd5, 6'd5, 6'd5, 6'd1, 4'b1111, 2'd0, NF, NF, NF, NF, 1'b1};
    vecs[4] = '{6'd3, 6'd0, 6'd3, 6'd5, 4'b0000, 2'd1, NF, 32'd26, 32'd16, NF, 1'b0};
    vecs[5] = '{6'd27, 6'd14, 6'd0, 6'd14, 4'b0101, 2'd3, NF, NF, NF, 32'd0, 1'b0};
    vecs[6] = '{6'd4, 6'd30, 6'd4, 6'd0, 4'b0000, 2'd2, NF, 32'd901, NF, 32'd901, 1'b0};
    for (int i = 0; i < 4; i++) prev[i] = NF;

    repeat (3) @(negedge Clk);
    chk_reset_vals("reset");
    Reset_n = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 7; i++) run_op(i);

    // start held high: one result every 7 cycles
    @(negedge Clk);
    drive(vecs[0]);
    start = 1'b1;
    done_cnt = 0; first = -1; last = -1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge Clk);
      if (done) begin
        done_cnt++;
        if (first < 0) first = c;
        if (last >= 0) chk("b2b_gap", 32'(c - last), 32'd7);
        last = c;
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(done_cnt), 32'd3);
    chk("b2b_first", 32'(first), 32'd6);
    push_exp(vecs[0]);
    chk_result("b2b", vecs[0].edead);
    @(negedge Clk);
    chk("b2b_idle", busy, 1'b0);

    // reset asserted during CALC1
    @(negedge Clk);
    drive(vecs[1]);
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge Clk);
    chk("mid_state_calc1", dbg_state, 3'd3);
    #2;
    Reset_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    for (int i = 0; i < 4; i++) prev[i] = NF;
    @(negedge Clk);
    Reset_n = 1'b1;
    start = 1'b1;
    @(negedge Clk);
    chk("release_start_ignored", busy, 1'b0);
    start = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (done) done_cnt++;
    end
    chk("no_done_after_reset", 32'(done_cnt), 32'd0);
    chk_hold("post_reset");
    run_op(2);
    run_op(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
